// File: rtl/lp_pkg.sv
// -----------------------------------------------------------------------------
// lp_pkg
// Shared definitions for the LP solver frame transmitter.
//   LP_A_W / LP_B_W : coefficient and bound widths of one frame row
//   lp_row_t        : one stored row {a1, a2, b}, raw signed bit copies
//   lp_tx_state_e   : transmitter FSM states
//   sat_inc16       : saturating 16-bit increment used by the statistics
//                     counters (only referenced when LP_TX_STATS_EN is defined)
// -----------------------------------------------------------------------------
package lp_pkg;

    localparam int LP_A_W = 6;
    localparam int LP_B_W = 12;

    typedef struct packed {
        logic signed [LP_A_W-1:0] a1;
        logic signed [LP_A_W-1:0] a2;
        logic signed [LP_B_W-1:0] b;
    } lp_row_t;

    localparam lp_row_t LP_ROW_ZERO = {6'd0, 6'd0, 12'd0};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } lp_tx_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lp_cfg_regfile.sv
// -----------------------------------------------------------------------------
// lp_cfg_regfile
// (MAX_CONS+1) x lp_row_t slot storage. Slot 0 holds the objective, slots
// 1..MAX_CONS hold constraint rows.
// Ports:
//   clk, rst         : clock, synchronous active-high clear of every slot
//   we, wr_addr,     : synchronous write port; indices above MAX_CONS are
//   wr_row             dropped
//   rd_addr, rd_row  : combinational read port; out-of-range reads give zero
// -----------------------------------------------------------------------------
module lp_cfg_regfile
    import lp_pkg::*;
#(
    parameter  int MAX_CONS = 8,
    localparam int AW       = $clog2(MAX_CONS + 1)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  lp_row_t       wr_row,
    input  logic [AW-1:0] rd_addr,
    output lp_row_t       rd_row
);

    localparam logic [AW-1:0] MAX_IDX = AW'(MAX_CONS);

    lp_row_t slots_r [MAX_CONS+1];

    // Slot storage: cleared by reset, otherwise takes in-range writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= MAX_CONS; i++) begin
                slots_r[i] <= LP_ROW_ZERO;
            end
        end else if (we && (wr_addr <= MAX_IDX)) begin
            slots_r[wr_addr] <= wr_row;
        end
    end

    // Combinational read port with a guard against unused index codes.
    always_comb begin
        if (rd_addr <= MAX_IDX) begin
            rd_row = slots_r[rd_addr];
        end else begin
            rd_row = LP_ROW_ZERO;
        end
    end

endmodule

// File: rtl/lp_frame_tx.sv
// -----------------------------------------------------------------------------
// lp_frame_tx
// Transmit side of the LP solver frame interface. The host fills slot 0
// (objective) and slots 1..MAX_CONS (constraints), then pulses start with a
// constraint count. One frame of cfg_num+1 beats is serialised onto lp_in_*,
// the solver result (or a timeout) is captured and offered on res_* under a
// valid/ready handshake.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   cfg_we, cfg_addr, cfg_a1/a2/b  : slot write, accepted only while idle
//   cfg_num, start                 : frame launch, count must be 1..MAX_CONS
//   busy                           : high from the first beat to handshake end
//   lp_in_valid, lp_in_a1/a2/b     : frame beats towards the solver
//   lp_out_valid, lp_out_max_value : solver result strobe and value
//   res_valid, res_value,          : captured result, timeout flag,
//   res_timeout, res_ready           host handshake
// Build option: define LP_TX_STATS_EN to add stat_frames (completed
// handshakes) and stat_stray (lp_out_valid seen outside WAIT), both 16-bit
// saturating counters.
// All outputs are registered.
// -----------------------------------------------------------------------------
module lp_frame_tx
    import lp_pkg::*;
#(
    parameter  int MAX_CONS = 8,
    parameter  int TIMEOUT  = 2**24 - 1,
    parameter  int TO_W     = 24,
    localparam int AW       = $clog2(MAX_CONS + 1)
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [AW-1:0]            cfg_addr,
    input  logic signed [LP_A_W-1:0] cfg_a1,
    input  logic signed [LP_A_W-1:0] cfg_a2,
    input  logic signed [LP_B_W-1:0] cfg_b,
    input  logic [AW-1:0]            cfg_num,
    input  logic                     start,
    output logic                     busy,
    output logic                     lp_in_valid,
    output logic signed [LP_A_W-1:0] lp_in_a1,
    output logic signed [LP_A_W-1:0] lp_in_a2,
    output logic signed [LP_B_W-1:0] lp_in_b,
    input  logic                     lp_out_valid,
    input  logic signed [LP_B_W-1:0] lp_out_max_value,
    output logic                     res_valid,
    output logic signed [LP_B_W-1:0] res_value,
    output logic                     res_timeout,
    input  logic                     res_ready
`ifdef LP_TX_STATS_EN
    ,
    output logic [15:0]              stat_frames,
    output logic [15:0]              stat_stray
`endif
);

    localparam logic [AW-1:0]   MAX_IDX = AW'(MAX_CONS);
    localparam logic [AW-1:0]   ONE_IDX = AW'(1'b1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_SAT  = {TO_W{1'b1}};

    lp_tx_state_e              state_r, state_nxt_s;
    logic [AW-1:0]             num_r, num_nxt_s;
    logic [AW-1:0]             beat_r, beat_nxt_s;
    logic [TO_W-1:0]           to_cnt_r, to_cnt_nxt_s;
    logic                      busy_r;
    logic                      in_valid_r, in_valid_nxt_s;
    lp_row_t                   in_row_r, in_row_nxt_s;
    logic                      res_valid_r, res_valid_nxt_s;
    logic signed [LP_B_W-1:0]  res_value_r, res_value_nxt_s;
    logic                      res_timeout_r, res_timeout_nxt_s;

    logic                      wr_en_s;
    lp_row_t                   wr_row_s;
    logic [AW-1:0]             rd_addr_s;
    lp_row_t                   rd_row_s;
    logic signed [LP_A_W-1:0]  beat0_a1_s, beat0_a2_s;

    assign wr_en_s  = cfg_we && (state_r == IDLE);
    assign wr_row_s = {cfg_a1, cfg_a2, cfg_b};

    lp_cfg_regfile #(
        .MAX_CONS (MAX_CONS)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (wr_en_s),
        .wr_addr (cfg_addr),
        .wr_row  (wr_row_s),
        .rd_addr (rd_addr_s),
        .rd_row  (rd_row_s)
    );

    // Read address: slot 0 while idle (beat 0), the next slot while sending.
    always_comb begin
        if (state_r == SEND) begin
            rd_addr_s = beat_r + ONE_IDX;
        end else begin
            rd_addr_s = {AW{1'b0}};
        end
    end

    // Beat 0 is loaded on the same edge that writes the slot, so a
    // simultaneous write to slot 0 is forwarded to keep write-before-start.
    always_comb begin
        if (cfg_we && (cfg_addr == {AW{1'b0}})) begin
            beat0_a1_s = cfg_a1;
            beat0_a2_s = cfg_a2;
        end else begin
            beat0_a1_s = rd_row_s.a1;
            beat0_a2_s = rd_row_s.a2;
        end
    end

    // Next-state and next-output logic for the frame FSM.
    always_comb begin
        state_nxt_s       = state_r;
        num_nxt_s         = num_r;
        beat_nxt_s        = beat_r;
        to_cnt_nxt_s      = to_cnt_r;
        in_valid_nxt_s    = 1'b0;
        in_row_nxt_s      = LP_ROW_ZERO;
        res_valid_nxt_s   = res_valid_r;
        res_value_nxt_s   = res_value_r;
        res_timeout_nxt_s = res_timeout_r;
        case (state_r)
            IDLE: begin
                if (start && (cfg_num != {AW{1'b0}}) && (cfg_num <= MAX_IDX)) begin
                    state_nxt_s     = SEND;
                    num_nxt_s       = cfg_num;
                    beat_nxt_s      = {AW{1'b0}};
                    in_valid_nxt_s  = 1'b1;
                    in_row_nxt_s.a1 = beat0_a1_s;
                    in_row_nxt_s.a2 = beat0_a2_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEND: begin
                // beat_r is the index currently on the bus.
                if (beat_r == num_r) begin
                    state_nxt_s  = WAIT;
                    to_cnt_nxt_s = {TO_W{1'b0}};
                end else begin
                    beat_nxt_s     = beat_r + ONE_IDX;
                    in_valid_nxt_s = 1'b1;
                    in_row_nxt_s   = rd_row_s;
                end
            end
            WAIT: begin
                // A result on the final counted cycle still beats the timeout.
                if (lp_out_valid) begin
                    state_nxt_s       = HOLD;
                    res_valid_nxt_s   = 1'b1;
                    res_value_nxt_s   = lp_out_max_value;
                    res_timeout_nxt_s = 1'b0;
                end else if (to_cnt_r == TO_LAST) begin
                    state_nxt_s       = HOLD;
                    res_valid_nxt_s   = 1'b1;
                    res_value_nxt_s   = 12'sd0;
                    res_timeout_nxt_s = 1'b1;
                end else if (to_cnt_r != TO_SAT) begin
                    to_cnt_nxt_s = to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
                end else begin
                    to_cnt_nxt_s = to_cnt_r;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_nxt_s     = IDLE;
                    res_valid_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            num_r         <= {AW{1'b0}};
            beat_r        <= {AW{1'b0}};
            to_cnt_r      <= {TO_W{1'b0}};
            busy_r        <= 1'b0;
            in_valid_r    <= 1'b0;
            in_row_r      <= LP_ROW_ZERO;
            res_valid_r   <= 1'b0;
            res_value_r   <= 12'sd0;
            res_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            num_r         <= num_nxt_s;
            beat_r        <= beat_nxt_s;
            to_cnt_r      <= to_cnt_nxt_s;
            busy_r        <= (state_nxt_s != IDLE);
            in_valid_r    <= in_valid_nxt_s;
            in_row_r      <= in_row_nxt_s;
            res_valid_r   <= res_valid_nxt_s;
            res_value_r   <= res_value_nxt_s;
            res_timeout_r <= res_timeout_nxt_s;
        end
    end

    assign busy        = busy_r;
    assign lp_in_valid = in_valid_r;
    assign lp_in_a1    = in_row_r.a1;
    assign lp_in_a2    = in_row_r.a2;
    assign lp_in_b     = in_row_r.b;
    assign res_valid   = res_valid_r;
    assign res_value   = res_value_r;
    assign res_timeout = res_timeout_r;

`ifdef LP_TX_STATS_EN
    logic [15:0] stat_frames_r;
    logic [15:0] stat_stray_r;

    // Saturating counters of completed handshakes and stray result strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_frames_r <= 16'd0;
            stat_stray_r  <= 16'd0;
        end else begin
            if ((state_r == HOLD) && res_ready) begin
                stat_frames_r <= sat_inc16(stat_frames_r);
            end
            if (lp_out_valid && (state_r != WAIT)) begin
                stat_stray_r <= sat_inc16(stat_stray_r);
            end
        end
    end

    assign stat_frames = stat_frames_r;
    assign stat_stray  = stat_stray_r;
`endif

endmodule

// File: tb/tb_lp_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_lp_frame_tx
// Self-checking bench for lp_frame_tx (MAX_CONS=8, TIMEOUT=16). A slot array
// kept in the bench mirrors host writes; expected frames are built from it
// as "objective a1/a2 with b=0, then slots 1..num in order, then idle".
// -----------------------------------------------------------------------------
module tb_lp_frame_tx;

    localparam int MAX_CONS = 8;
    localparam int TIMEOUT  = 16;
    localparam int TO_W     = 24;
    localparam int AW       = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_we;
    logic [AW-1:0]     cfg_addr;
    logic [5:0]        cfg_a1, cfg_a2;
    logic [11:0]       cfg_b;
    logic [AW-1:0]     cfg_num;
    logic              start;
    logic              busy;
    logic              lp_in_valid;
    logic [5:0]        lp_in_a1, lp_in_a2;
    logic [11:0]       lp_in_b;
    logic              lp_out_valid;
    logic [11:0]       lp_out_max_value;
    logic              res_valid;
    logic [11:0]       res_value;
    logic              res_timeout;
    logic              res_ready;
`ifdef LP_TX_STATS_EN
    logic [15:0]       stat_frames, stat_stray;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference state: slot contents and expected statistics.
    logic [5:0]  m_a1 [0:MAX_CONS];
    logic [5:0]  m_a2 [0:MAX_CONS];
    logic [11:0] m_b  [0:MAX_CONS];
    int          exp_frames;
    int          exp_stray;

    // Observed and expected beat windows (beats 0..num plus one idle sample).
    logic        ov  [0:11];
    logic [5:0]  oa1 [0:11];
    logic [5:0]  oa2 [0:11];
    logic [11:0] ob  [0:11];
    logic        ev  [0:11];
    logic [5:0]  ea1 [0:11];
    logic [5:0]  ea2 [0:11];
    logic [11:0] eb  [0:11];

    lp_frame_tx #(
        .MAX_CONS (MAX_CONS),
        .TIMEOUT  (TIMEOUT),
        .TO_W     (TO_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_we           (cfg_we),
        .cfg_addr         (cfg_addr),
        .cfg_a1           (cfg_a1),
        .cfg_a2           (cfg_a2),
        .cfg_b            (cfg_b),
        .cfg_num          (cfg_num),
        .start            (start),
        .busy             (busy),
        .lp_in_valid      (lp_in_valid),
        .lp_in_a1         (lp_in_a1),
        .lp_in_a2         (lp_in_a2),
        .lp_in_b          (lp_in_b),
        .lp_out_valid     (lp_out_valid),
        .lp_out_max_value (lp_out_max_value),
        .res_valid        (res_valid),
        .res_value        (res_value),
        .res_timeout      (res_timeout),
        .res_ready        (res_ready)
`ifdef LP_TX_STATS_EN
        ,
        .stat_frames      (stat_frames),
        .stat_stray       (stat_stray)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int idx);
        ov[idx]  = lp_in_valid;
        oa1[idx] = lp_in_a1;
        oa2[idx] = lp_in_a2;
        ob[idx]  = lp_in_b;
    endtask

    task automatic model_clear();
        for (int i = 0; i <= MAX_CONS; i++) begin
            m_a1[i] = 6'd0;
            m_a2[i] = 6'd0;
            m_b[i]  = 12'd0;
        end
        exp_frames = 0;
        exp_stray  = 0;
    endtask

    task automatic build_expected(input int num);
        for (int i = 0; i < 12; i++) begin
            ev[i] = 1'b0; ea1[i] = 6'd0; ea2[i] = 6'd0; eb[i] = 12'd0;
        end
        ev[0] = 1'b1; ea1[0] = m_a1[0]; ea2[0] = m_a2[0];
        for (int k = 1; k <= num; k++) begin
            ev[k] = 1'b1; ea1[k] = m_a1[k]; ea2[k] = m_a2[k]; eb[k] = m_b[k];
        end
    endtask

    task automatic cfg_write(input int addr, input logic [5:0] a1, input logic [5:0] a2,
                             input logic [11:0] b);
        cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_a1 = a1; cfg_a2 = a2; cfg_b = b;
        tick();
        cfg_we = 1'b0;
        if (addr <= MAX_CONS) begin
            m_a1[addr] = a1; m_a2[addr] = a2; m_b[addr] = b;
        end
    endtask

    // Pulse start and record num+2 beat samples; ends on the first WAIT cycle.
    task automatic launch(input int num);
        cfg_num = AW'(num);
        start   = 1'b1;
        tick();
        start   = 1'b0;
        sample(0);
        for (int i = 1; i <= num + 1; i++) begin
            tick();
            sample(i);
        end
    endtask

    // Deliver a solver result during WAIT and complete the handshake.
    task automatic complete(input logic [11:0] v);
        lp_out_valid = 1'b1; lp_out_max_value = v;
        tick();
        lp_out_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        exp_frames++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, lp_in_valid, lp_in_a1, lp_in_a2, lp_in_b, res_valid, res_value, res_timeout} !== 40'd0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b v=%b a1=%0d a2=%0d b=%0d rv=%b val=%0d to=%b, expected all 0",
                     busy, lp_in_valid, lp_in_a1, lp_in_a2, lp_in_b, res_valid, res_value, res_timeout);
        end
`ifdef LP_TX_STATS_EN
        checks++;
        if ({stat_frames, stat_stray} !== 32'd0) begin
            failures++;
            $display("FAIL reset_stats got frames=%0d stray=%0d, expected 0 0", stat_frames, stat_stray);
        end
`endif
        rst = 1'b0;
        model_clear();
        tick();
    endtask

    task automatic test_basic();
        int d;
        cfg_write(0, 6'd3, 6'd2, 12'($urandom));
        cfg_write(1, 6'd1, 6'd0, 12'd10);
        cfg_write(2, 6'd0, 6'd1, 12'd10);
        cfg_write(3, 6'd1, 6'd1, 12'd15);
        launch(3);
        build_expected(3);
        for (int i = 0; i <= 4; i++) begin
            checks++;
            if (ov[i] !== ev[i] || oa1[i] !== ea1[i] || oa2[i] !== ea2[i] || ob[i] !== eb[i]) begin
                failures++;
                $display("FAIL basic_beat%0d got v=%b a1=%0d a2=%0d b=%0d, expected v=%b a1=%0d a2=%0d b=%0d",
                         i, ov[i], $signed(oa1[i]), $signed(oa2[i]), $signed(ob[i]),
                         ev[i], $signed(ea1[i]), $signed(ea2[i]), $signed(eb[i]));
            end
        end
        d = $urandom_range(0, 8);
        for (int i = 0; i < d; i++) tick();
        checks++;
        if (busy !== 1'b1 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_wait got busy=%b rv=%b, expected busy=1 rv=0", busy, res_valid);
        end
        lp_out_valid = 1'b1; lp_out_max_value = 12'd40;
        tick();
        lp_out_valid = 1'b0;
        d = $urandom_range(1, 4);
        for (int i = 0; i < d; i++) begin
            // A strobe during HOLD must not disturb the held result.
            if (i == 0) begin
                lp_out_valid = 1'b1; lp_out_max_value = 12'd99; exp_stray++;
            end else begin
                lp_out_valid = 1'b0;
            end
            checks++;
            if (res_valid !== 1'b1 || res_value !== 12'd40 || res_timeout !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL basic_hold got rv=%b val=%0d to=%b busy=%b, expected rv=1 val=40 to=0 busy=1",
                         res_valid, $signed(res_value), res_timeout, busy);
            end
            tick();
        end
        lp_out_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        exp_frames++;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_handshake got rv=%b busy=%b, expected 0 0", res_valid, busy);
        end
    endtask

    task automatic test_timeout();
        int num;
        logic [11:0] v;
        for (int k = 0; k <= MAX_CONS; k++) cfg_write(k, 6'($urandom), 6'($urandom), 12'($urandom));
        num = $urandom_range(1, MAX_CONS);
        launch(num);
        for (int i = 1; i <= TIMEOUT; i++) begin
            tick();
            checks++;
            if (res_valid !== (i == TIMEOUT)) begin
                failures++;
                $display("FAIL timeout_wait%0d got rv=%b, expected %b", i, res_valid, (i == TIMEOUT));
            end
        end
        checks++;
        if (res_timeout !== 1'b1 || res_value !== 12'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_flag got to=%b val=%0d busy=%b, expected to=1 val=0 busy=1",
                     res_timeout, $signed(res_value), busy);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        exp_frames++;
        // Result arriving on the last counted cycle wins over the timeout.
        launch(num);
        for (int i = 1; i < TIMEOUT; i++) tick();
        v = 12'($urandom);
        complete(v);
        launch(1);
        for (int i = 1; i < TIMEOUT; i++) tick();
        lp_out_valid = 1'b1; lp_out_max_value = v;
        tick();
        lp_out_valid = 1'b0;
        checks++;
        if (res_valid !== 1'b1 || res_timeout !== 1'b0 || res_value !== v) begin
            failures++;
            $display("FAIL timeout_tie got rv=%b to=%b val=%0d, expected rv=1 to=0 val=%0d",
                     res_valid, res_timeout, $signed(res_value), $signed(v));
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        exp_frames++;
    endtask

    task automatic test_ignore_in_send();
        for (int k = 0; k <= 3; k++) cfg_write(k, 6'($urandom), 6'($urandom), 12'($urandom));
        for (int pass = 0; pass < 2; pass++) begin
            cfg_num = AW'(3);
            start = 1'b1;
            tick();
            sample(0);
            if (pass == 0) begin
                start = 1'b1; cfg_num = AW'(8);
                cfg_we = 1'b1; cfg_addr = AW'(2); cfg_a1 = 6'd5; cfg_a2 = 6'd5; cfg_b = 12'd5;
                lp_out_valid = 1'b1; lp_out_max_value = 12'($urandom);
                exp_stray++;
            end else begin
                start = 1'b0;
            end
            tick();
            sample(1);
            start = 1'b0; cfg_we = 1'b0; lp_out_valid = 1'b0;
            for (int i = 2; i <= 4; i++) begin
                tick();
                sample(i);
            end
            build_expected(3);
            for (int i = 0; i <= 4; i++) begin
                checks++;
                if (ov[i] !== ev[i] || oa1[i] !== ea1[i] || oa2[i] !== ea2[i] || ob[i] !== eb[i]) begin
                    failures++;
                    $display("FAIL send_ignore_p%0d_beat%0d got v=%b a1=%0d a2=%0d b=%0d, expected v=%b a1=%0d a2=%0d b=%0d",
                             pass, i, ov[i], $signed(oa1[i]), $signed(oa2[i]), $signed(ob[i]),
                             ev[i], $signed(ea1[i]), $signed(ea2[i]), $signed(eb[i]));
                end
            end
            complete(12'($urandom));
            checks++;
            if (busy !== 1'b0 || lp_in_valid !== 1'b0) begin
                failures++;
                $display("FAIL send_ignore_idle got busy=%b v=%b, expected 0 0", busy, lp_in_valid);
            end
        end
`ifdef LP_TX_STATS_EN
        checks++;
        if (stat_stray !== 16'(exp_stray) || stat_frames !== 16'(exp_frames)) begin
            failures++;
            $display("FAIL stats_count got frames=%0d stray=%0d, expected %0d %0d",
                     stat_frames, stat_stray, exp_frames, exp_stray);
        end
`endif
    endtask

    task automatic test_bad_num();
        int bad [3];
        bad[0] = 0; bad[1] = MAX_CONS + 1; bad[2] = 15;
        for (int j = 0; j < 3; j++) begin
            cfg_num = AW'(bad[j]);
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (busy !== 1'b0 || lp_in_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL bad_num%0d got busy=%b v=%b, expected 0 0", bad[j], busy, lp_in_valid);
                end
                tick();
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int k = 0; k <= 3; k++) cfg_write(k, 6'($urandom_range(1, 63)), 6'($urandom), 12'($urandom));
        cfg_num = AW'(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checks++;
        if (lp_in_valid !== 1'b1 || lp_in_a1 !== m_a1[2]) begin
            failures++;
            $display("FAIL rst_mid_beat2 got v=%b a1=%0d, expected v=1 a1=%0d", lp_in_valid, $signed(lp_in_a1), $signed(m_a1[2]));
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        checks++;
        if ({lp_in_valid, busy, res_valid, lp_in_a1, lp_in_a2, lp_in_b} !== 27'd0) begin
            failures++;
            $display("FAIL rst_mid_outputs got v=%b busy=%b rv=%b a1=%0d a2=%0d b=%0d, expected all 0",
                     lp_in_valid, busy, res_valid, lp_in_a1, lp_in_a2, lp_in_b);
        end
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                for (int k = 0; k <= 3; k++) cfg_write(k, 6'($urandom), 6'($urandom), 12'($urandom));
            end
            launch(3);
            build_expected(3);
            for (int i = 0; i <= 4; i++) begin
                checks++;
                if (ov[i] !== ev[i] || oa1[i] !== ea1[i] || oa2[i] !== ea2[i] || ob[i] !== eb[i]) begin
                    failures++;
                    $display("FAIL rst_after_p%0d_beat%0d got v=%b a1=%0d a2=%0d b=%0d, expected v=%b a1=%0d a2=%0d b=%0d",
                             pass, i, ov[i], $signed(oa1[i]), $signed(oa2[i]), $signed(ob[i]),
                             ev[i], $signed(ea1[i]), $signed(ea2[i]), $signed(eb[i]));
                end
            end
            complete(12'($urandom));
        end
    endtask

    task automatic test_random_frames();
        int num, d, addr;
        logic [11:0] v;
        for (int it = 0; it < 6; it++) begin
            for (int w = 0; w < 6; w++) begin
                addr = $urandom_range(0, 15);
                cfg_write(addr, 6'($urandom), 6'($urandom), 12'($urandom));
            end
            num = $urandom_range(1, MAX_CONS);
            launch(num);
            build_expected(num);
            for (int i = 0; i <= num + 1; i++) begin
                checks++;
                if (ov[i] !== ev[i] || oa1[i] !== ea1[i] || oa2[i] !== ea2[i] || ob[i] !== eb[i]) begin
                    failures++;
                    $display("FAIL rand%0d_beat%0d got v=%b a1=%0d a2=%0d b=%0d, expected v=%b a1=%0d a2=%0d b=%0d",
                             it, i, ov[i], $signed(oa1[i]), $signed(oa2[i]), $signed(ob[i]),
                             ev[i], $signed(ea1[i]), $signed(ea2[i]), $signed(eb[i]));
                end
            end
            d = $urandom_range(0, TIMEOUT - 2);
            for (int i = 0; i < d; i++) tick();
            v = 12'($urandom);
            lp_out_valid = 1'b1; lp_out_max_value = v;
            tick();
            lp_out_valid = 1'b0;
            checks++;
            if (res_valid !== 1'b1 || res_value !== v || res_timeout !== 1'b0) begin
                failures++;
                $display("FAIL rand%0d_result got rv=%b val=%0d to=%b, expected rv=1 val=%0d to=0",
                         it, res_valid, $signed(res_value), res_timeout, $signed(v));
            end
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            exp_frames++;
        end
    endtask

    task automatic test_full_frame();
        logic [5:0] n_a1, n_a2;
        for (int k = 0; k <= MAX_CONS; k++) cfg_write(k, 6'b100000, 6'b011111, 12'h800);
        launch(MAX_CONS);
        build_expected(MAX_CONS);
        for (int i = 0; i <= MAX_CONS + 1; i++) begin
            checks++;
            if (ov[i] !== ev[i] || oa1[i] !== ea1[i] || oa2[i] !== ea2[i] || ob[i] !== eb[i]) begin
                failures++;
                $display("FAIL full_beat%0d got v=%b a1=%0d a2=%0d b=%0d, expected v=%b a1=%0d a2=%0d b=%0d",
                         i, ov[i], $signed(oa1[i]), $signed(oa2[i]), $signed(ob[i]),
                         ev[i], $signed(ea1[i]), $signed(ea2[i]), $signed(eb[i]));
            end
        end
        res_ready = 1'b1;
        lp_out_valid = 1'b1; lp_out_max_value = 12'h800;
        tick();
        lp_out_valid = 1'b0;
        checks++;
        if (res_valid !== 1'b1 || res_value !== 12'h800 || res_timeout !== 1'b0) begin
            failures++;
            $display("FAIL full_result got rv=%b val=%0d to=%b, expected rv=1 val=-2048 to=0",
                     res_valid, $signed(res_value), res_timeout);
        end
        tick();
        res_ready = 1'b0;
        exp_frames++;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || lp_in_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_return got rv=%b busy=%b v=%b, expected 0 0 0", res_valid, busy, lp_in_valid);
        end
        // Back-to-back start with a same-cycle objective write.
        n_a1 = 6'($urandom); n_a2 = 6'($urandom);
        cfg_we = 1'b1; cfg_addr = AW'(0); cfg_a1 = n_a1; cfg_a2 = n_a2; cfg_b = 12'($urandom);
        m_a1[0] = n_a1; m_a2[0] = n_a2; m_b[0] = cfg_b;
        cfg_num = AW'(2);
        start = 1'b1;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        sample(0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            sample(i);
        end
        build_expected(2);
        for (int i = 0; i <= 3; i++) begin
            checks++;
            if (ov[i] !== ev[i] || oa1[i] !== ea1[i] || oa2[i] !== ea2[i] || ob[i] !== eb[i]) begin
                failures++;
                $display("FAIL b2b_beat%0d got v=%b a1=%0d a2=%0d b=%0d, expected v=%b a1=%0d a2=%0d b=%0d",
                         i, ov[i], $signed(oa1[i]), $signed(oa2[i]), $signed(ob[i]),
                         ev[i], $signed(ea1[i]), $signed(ea2[i]), $signed(eb[i]));
            end
        end
        complete(12'($urandom));
`ifdef LP_TX_STATS_EN
        checks++;
        if (stat_stray !== 16'(exp_stray) || stat_frames !== 16'(exp_frames)) begin
            failures++;
            $display("FAIL stats_final got frames=%0d stray=%0d, expected %0d %0d",
                     stat_frames, stat_stray, exp_frames, exp_stray);
        end
`endif
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = 4'd0; cfg_a1 = 6'd0; cfg_a2 = 6'd0; cfg_b = 12'd0;
        cfg_num = 4'd0; start = 1'b0; lp_out_valid = 1'b0; lp_out_max_value = 12'd0; res_ready = 1'b0;
        model_clear();
        test_reset();
        test_basic();
        test_timeout();
        test_ignore_in_send();
        test_bad_num();
        test_reset_mid_frame();
        test_random_frames();
        test_full_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
